fifo_ctrl: RTL and testbench

//  Sequencing controller for the fifo_mem register bank (DEPTH x d_ff_n slots, BITS wide).

---
 rtl/fifo_pkg.sv | 18 +
 rtl/ptr_wrap.sv | 30 +++
 rtl/fifo_ctrl.sv | 127 ++++++++++++
 tb/tb_fifo_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and helpers for the fifo_mem slice
// Purpose: default geometry for the register-bank FIFO and a slot-select helper.
// Ports: none (package).
package fifo_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int BITS_DEF  = 8;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  // One-hot slot select for the default geometry.
  function automatic logic [DEPTH_DEF-1:0] onehot(input logic [AW_DEF-1:0] ptr);
    logic [DEPTH_DEF-1:0] v;
    v = '0;
    v[ptr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ptr_wrap.sv
// rtl/ptr_wrap.sv - AW-bit wrapping pointer with enable and synchronous clear
// Purpose: holds one FIFO pointer; advances by one per enabled edge, wrapping
//          naturally at 2**AW (DEPTH is a power of two).
// Ports:
//   i_clk  clock
//   i_clr  synchronous active-high clear to 0
//   i_en   advance enable
//   o_ptr  current pointer value
module ptr_wrap #(
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and status sequencer for the fifo_mem bank
// Purpose: accepts producer/consumer requests, drives the one-hot slot load
//          enables and the read-mux select, tracks occupancy, level flags and
//          sticky overflow/underflow errors. Carries no data.
// Ports:
//   i_clk          clock, all state on posedge
//   i_clr          synchronous active-high reset
//   i_wr_req       producer write request
//   i_rd_req       consumer read request
//   i_err_clr      clears sticky o_ovf/o_udf
//   o_wr_en        one-hot slot load enable (combinational)
//   o_rd_sel       read-mux select (oldest word)
//   o_count        occupancy 0..DEPTH
//   o_empty        count == 0
//   o_full         count == DEPTH
//   o_almost_full  count >= AF_LVL
//   o_ovf          sticky: write requested while full
//   o_udf          sticky: read requested while empty
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int AF_LVL = DEPTH - 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_wr_req,
  input  logic          i_rd_req,
  input  logic          i_err_clr,
  output logic [DEPTH-1:0] o_wr_en,
  output logic [AW-1:0] o_rd_sel,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_almost_full,
  output logic          o_ovf,
  output logic          o_udf
);

  localparam int CW = AW + 1;

  logic [AW-1:0] w_wptr;
  logic [AW-1:0] w_rptr;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [CW-1:0] w_count_nxt;

  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_af;
  logic          r_ovf;
  logic          r_udf;

  // Acceptance uses the registered flags only, so neither request can reach
  // the other side's outputs combinationally. Clear suppresses slot loads.
  assign w_wr_acc = i_wr_req & ~r_full & ~i_clr;
  assign w_rd_acc = i_rd_req & ~r_empty;

  ptr_wrap #(.AW(AW)) u_wptr (
    .i_clk (i_clk),
    .i_clr (i_clr),
    .i_en  (w_wr_acc),
    .o_ptr (w_wptr)
  );

  ptr_wrap #(.AW(AW)) u_rptr (
    .i_clk (i_clk),
    .i_clr (i_clr),
    .i_en  (w_rd_acc),
    .o_ptr (w_rptr)
  );

  always_comb begin
    o_wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_wr_en[i] = w_wr_acc & (w_wptr == AW'(i));
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags are computed from the next count so they line up with o_count.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_af    <= (w_count_nxt >= CW'(AF_LVL));
      // A new error takes priority over a coincident clear.
      if (i_wr_req && r_full) begin
        r_ovf <= 1'b1;
      end else if (i_err_clr) begin
        r_ovf <= 1'b0;
      end
      if (i_rd_req && r_empty) begin
        r_udf <= 1'b1;
      end else if (i_err_clr) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign o_rd_sel      = w_rptr;
  assign o_count       = r_count;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_af;
  assign o_ovf         = r_ovf;
  assign o_udf         = r_udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl (DEPTH=4)
module tb_fifo_ctrl;

  localparam int DEPTH = 4;

  logic       clk;
  logic       clr;
  logic       wr_req;
  logic       rd_req;
  logic       err_clr;
  logic [3:0] wr_en;
  logic [1:0] rd_sel;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       ovf;
  logic       udf;

  int vectors;
  int miscompares;

  // Reference model: totals of accepted writes/reads and current occupancy.
  int  m_nwr;
  int  m_nrd;
  int  m_cnt;
  bit  m_ovf;
  bit  m_udf;

  fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_clr         (clr),
    .i_wr_req      (wr_req),
    .i_rd_req      (rd_req),
    .i_err_clr     (err_clr),
    .o_wr_en       (wr_en),
    .o_rd_sel      (rd_sel),
    .o_count       (count),
    .o_empty       (empty),
    .o_full        (full),
    .o_almost_full (almost_full),
    .o_ovf         (ovf),
    .o_udf         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit ec, input bit cl);
    logic [31:0] exp_wen;
    bit wa, ra;
    @(negedge clk);
    wr_req  = wr;
    rd_req  = rd;
    err_clr = ec;
    clr     = cl;
    #1;
    exp_wen = (!cl && wr && m_cnt < DEPTH) ? (32'd1 << (m_nwr % DEPTH)) : 32'd0;
    chk("wr_en", 32'(wr_en), exp_wen);
    @(posedge clk);
    if (cl) begin
      m_nwr = 0; m_nrd = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
    end else begin
      wa = wr && (m_cnt < DEPTH);
      ra = rd && (m_cnt > 0);
      if (wr && m_cnt == DEPTH) m_ovf = 1;
      else if (ec)              m_ovf = 0;
      if (rd && m_cnt == 0)     m_udf = 1;
      else if (ec)              m_udf = 0;
      m_cnt = m_cnt + int'(wa) - int'(ra);
      m_nwr = m_nwr + int'(wa);
      m_nrd = m_nrd + int'(ra);
    end
    #1;
    chk("count",       32'(count),       32'(m_cnt));
    chk("empty",       32'(empty),       32'(m_cnt == 0));
    chk("full",        32'(full),        32'(m_cnt == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= DEPTH - 1));
    chk("ovf",         32'(ovf),         32'(m_ovf));
    chk("udf",         32'(udf),         32'(m_udf));
    chk("rd_sel",      32'(rd_sel),      32'(m_nrd % DEPTH));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_nwr = 0; m_nrd = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
    clr = 1'b1; wr_req = 1'b0; rd_req = 1'b0; err_clr = 1'b0;

    // Reset for two cycles.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Fill: wr_en walks 0001..1000, almost_full after 3rd, full after 4th.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      if (i == 2) chk("af_at_3", 32'(almost_full), 32'd1);
    end
    chk("full_at_4", 32'(full), 32'd1);

    // Overflow, then clear it.
    step(1, 0, 0, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    step(0, 0, 1, 0);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Full with both requests: read wins, ovf set, count -> 3.
    step(1, 1, 0, 0);
    chk("full_both_cnt", 32'(count), 32'd3);

    // Drain, then underflow while empty.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk("udf_set", 32'(udf), 32'd1);
    // Empty with both requests: write wins, count -> 1.
    step(1, 1, 0, 0);
    chk("empty_both_cnt", 32'(count), 32'd1);

    // Occupancy 2 held across 6 simultaneous rd+wr cycles; pointers wrap.
    step(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    chk("steady_cnt", 32'(count), 32'd2);

    // Clear mid-operation with a write pending.
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("clr_mid_cnt", 32'(count), 32'd0);
    chk("clr_mid_sel", 32'(rd_sel), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 99) < 10), bit'($urandom_range(0, 99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
